// File: rtl/alu_out_stage.sv
// ALUOut register: two-entry skid buffer between the ALU and writeback/PC update.
// Optional taken-branch counter enabled by defining ALU_OUT_TAKEN_CNT_EN.
module alu_out_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RD_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] result,
  input  logic             zero,
  input  logic             sign,
  input  logic [2:0]       br_type,
  input  logic [RD_W-1:0]  rd,
  input  logic             wr_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             out_zero,
  output logic             out_sign,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_wr_en,
  output logic             branch_taken
`ifdef ALU_OUT_TAKEN_CNT_EN
  ,
  output logic [CNT_W-1:0] taken_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StHalf, StFull} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             s;
    logic [RD_W-1:0]  dst;
    logic             we;
    logic             tk;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_ready_q, in_ready_d;
  logic   accept, pop;

  function automatic logic eval_branch(input logic [2:0] bt, input logic z, input logic s);
    logic tk;
    case (bt)
      3'b001:  tk = z;
      3'b010:  tk = !z;
      3'b011:  tk = s;
      3'b100:  tk = !s;
      3'b101:  tk = !s && !z;
      3'b110:  tk = s || z;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    in_entry     = '0;
    in_entry.res = result;
    in_entry.z   = zero;
    in_entry.s   = sign;
    in_entry.dst = rd;
    in_entry.we  = wr_en;
    in_entry.tk  = eval_branch(br_type, zero, sign);
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Payload may go stale, but nothing downstream may act on it.
      state_d   = StEmpty;
      main_d.we = 1'b0;
      main_d.tk = 1'b0;
      skid_d.we = 1'b0;
      skid_d.tk = 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = StHalf;
          end
        end
        StHalf: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only a pop can occur.
          if (pop) begin
            main_d  = skid_q;
            state_d = StHalf;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign alu_out      = main_q.res;
  assign out_zero     = main_q.z;
  assign out_sign     = main_q.s;
  assign out_rd       = main_q.dst;
  assign out_wr_en    = main_q.we;
  assign branch_taken = main_q.tk;

`ifdef ALU_OUT_TAKEN_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Pops in a flush cycle are discarded, so they are not counted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (pop && main_q.tk && !flush) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign taken_cnt = cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: doc/alu_out_stage.md
Name: alu_out_stage

Overview:
- Registered output stage directly downstream of the 32-bit ALU in the multi-cycle CPU. It serves as the ALUOut register.
- Captures the ALU result together with the zero and sign flags, the destination register and the write enable, and evaluates the branch condition at capture.
- Presents the captured entry to the writeback/PC-update stage through a valid/ready handshake.
- A two-entry skid buffer gives full throughput without a combinational path from out_ready to in_ready.

Parameters:
- WIDTH, 32, data width of the ALU result.
- RD_W, 5, destination register index width.
- CNT_W, 16, width of the taken-branch counter (optional feature only).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  stage can accept.
- result  input  WIDTH  ALU result.
- zero  input  1  ALU zero flag.
- sign  input  1  ALU sign flag (result[WIDTH-1]).
- br_type  input  3  branch kind: 000 none, 001 beq, 010 bne, 011 bltz, 100 bgez, 101 bgtz, 110 blez, 111 reserved.
- rd  input  RD_W  destination register.
- wr_en  input  1  register write request.
- out_valid  output  1  entry available.
- out_ready  input  1  consumer accepts.
- alu_out  output  WIDTH  captured result.
- out_zero  output  1  captured zero flag.
- out_sign  output  1  captured sign flag.
- out_rd  output  RD_W  captured destination.
- out_wr_en  output  1  captured write enable.
- branch_taken  output  1  branch condition true for the presented entry.

Behaviour:
- Handshake terms:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Reset (RST low, asynchronous):
  - State goes to EMPTY.
  - out_valid=0, in_ready=1.
  - alu_out, out_zero, out_sign, out_rd, out_wr_en and branch_taken all 0.
  - Skid register is cleared.
  - Reset asserted mid-transfer discards all entries.
- Branch condition is evaluated from the input flags at accept and stored with the entry:
  - beq: zero.
  - bne: !zero.
  - bltz: sign.
  - bgez: !sign.
  - bgtz: !sign & !zero.
  - blez: sign | zero.
  - none and reserved: 0.
- FSM states EMPTY, HALF and FULL. Main register drives the outputs; the skid register holds the second entry.
  - EMPTY: accept -> load main, go to HALF.
  - HALF, accept & pop -> load main, stay in HALF.
  - HALF, accept only -> load skid, go to FULL.
  - HALF, pop only -> EMPTY.
  - HALF, neither -> hold.
  - FULL: pop -> main<=skid, go to HALF. No accept is possible in FULL.
- in_ready is registered: 1 in EMPTY and HALF, 0 in FULL. It does not depend combinationally on out_ready.
- out_valid = 1 in HALF and FULL.
- Latency: an entry accepted in cycle N is presented with out_valid=1 in cycle N+1 when the stage was EMPTY, or when it was HALF with a simultaneous pop.
- All outputs stay stable while out_valid & !out_ready. Ordering is strict FIFO.
- flush (synchronous, highest priority below reset):
  - Next state is EMPTY and out_valid goes to 0.
  - Any accept or pop in the flush cycle is discarded.
  - Payload registers may keep their stale values. out_wr_en and branch_taken are cleared.
- No arithmetic is performed on the data; all widths pass through unchanged.

Optional Feature:
- ALU_OUT_TAKEN_CNT_EN
  - Defined:
    - Adds output port taken_cnt [CNT_W-1:0], reset to 0.
    - Increments by 1 on each pop where branch_taken=1.
    - Wraps from all-ones to 0.
    - Unaffected by flush.
  - Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_valid=1, result=0x0000_0005, zero=0, sign=0, br_type=010, rd=3, wr_en=1 with out_ready=1 -> next cycle out_valid=1, alu_out=5, branch_taken=1, out_rd=3. Continuous stream sustains one transfer per cycle.
- Backpressure: out_ready=0, push 0x11 then 0x22 -> in_ready goes 0 after the second accept and alu_out holds 0x11. Raise out_ready -> 0x11 then 0x22 pop in order and in_ready returns to 1.
- Branch table: with result=0 (zero=1), result=0x8000_0000 (sign=1) and result=7, run every br_type -> branch_taken matches the truth table above; br_type=111 always gives 0.
- Flush while FULL with out_ready=0, together with an in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the incoming entry is dropped.
- RST pulsed low asynchronously mid-cycle while HALF -> out_valid drops immediately, all outputs 0, in_ready=1 after release.
- With ALU_OUT_TAKEN_CNT_EN and CNT_W=2, pop 5 taken beq entries -> taken_cnt reads 1, 2, 3, 0, 1. Untaken pops leave it unchanged.
